// File: rtl/rv32_memory_pipe.sv
// rtl/rv32_memory_pipe.sv - RV32 memory stage with parametrised data-memory read latency
module rv32_memory_pipe #(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        valid_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        reg_write_i,
   input  logic        memory_write_i,
   input  logic        memory_read_i,
   input  logic [2:0]  result_source_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] write_data_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_next_i,
   input  logic [31:0] memory_read_data_i,
   output logic        memory_enable_o,
   output logic [3:0]  memory_write_enable_o,
   output logic [31:0] memory_data_address_o,
   output logic [31:0] memory_write_data_o,
   output logic        valid_o,
   output logic        reg_write_o,
   output logic        misaligned_o,
   output logic [2:0]  result_source_o,
   output logic [31:0] alu_result_o,
   output logic [31:0] read_data_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_next_o
);

   // In-flight entry; is_load is needed only to decide whether read data is formatted
   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        is_load;
      logic        misaligned;
      logic [2:0]  result_source;
      logic [31:0] alu_result;
      logic [31:0] instr;
      logic [31:0] pc_next;
   } entry_t;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        misaligned;
      logic [2:0]  result_source;
      logic [31:0] alu_result;
      logic [31:0] instr;
      logic [31:0] pc_next;
      logic [31:0] read_data;
   } wb_t;

   logic [2:0]  f3;
   logic [1:0]  a;
   logic        aligned;
   logic        misaligned_in;
   logic        store_go;
   logic [3:0]  strobe;
   logic [31:0] store_data;
   entry_t      in_e;
   entry_t      last;
   entry_t      stage_q [MEM_LATENCY];
   entry_t      stage_d [MEM_LATENCY];
   wb_t         wb_q, wb_d;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign f3            = instr_i[14:12];
   assign a             = alu_result_i[1:0];
   assign aligned       = (f3[1:0] == 2'b00) | ((f3[1:0] == 2'b01) & !a[0]) |
                          ((f3[1:0] == 2'b10) & (a == 2'b00));
   assign misaligned_in = valid_i & (memory_read_i | memory_write_i) & !aligned;
   assign store_go      = valid_i & memory_write_i & aligned & !stall_i & !flush_i;

   // Store lane strobes and replicated write data; strobes only fire when the store really advances
   always_comb begin
      strobe     = 4'b0000;
      store_data = write_data_i;
      case (f3[1:0])
         2'b00: begin
            strobe     = 4'b0001 << a;
            store_data = {4{write_data_i[7:0]}};
         end
         2'b01: begin
            strobe     = 4'b0011 << a;
            store_data = {2{write_data_i[15:0]}};
         end
         2'b10: strobe = 4'b1111;
         default: strobe = 4'b0000;
      endcase
      if (!store_go) strobe = 4'b0000;
   end

   assign memory_enable_o       = !stall_i;
   assign memory_write_enable_o = strobe;
   assign memory_data_address_o = alu_result_i;
   assign memory_write_data_o   = store_data;

   // New entry from the execute slot; faulting or invalid entries never write rd
   always_comb begin
      in_e               = '0;
      in_e.valid         = valid_i;
      in_e.reg_write     = valid_i & reg_write_i & !misaligned_in;
      in_e.is_load       = memory_read_i;
      in_e.misaligned    = misaligned_in;
      in_e.result_source = result_source_i;
      in_e.alu_result    = alu_result_i;
      in_e.instr         = instr_i;
      in_e.pc_next       = pc_next_i;
   end

   assign last = stage_q[MEM_LATENCY-1];

   // Load lane select and extension for the entry leaving the last memory stage
   always_comb begin
      ld_data = 32'h0;
      case (last.alu_result[1:0])
         2'b00:   ld_byte = memory_read_data_i[7:0];
         2'b01:   ld_byte = memory_read_data_i[15:8];
         2'b10:   ld_byte = memory_read_data_i[23:16];
         default: ld_byte = memory_read_data_i[31:24];
      endcase
      ld_half = last.alu_result[1] ? memory_read_data_i[31:16] : memory_read_data_i[15:0];
      if (last.is_load && !last.misaligned) begin
         case (last.instr[14:12])
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            3'b010:  ld_data = memory_read_data_i;
            default: ld_data = 32'h0;
         endcase
      end
   end

   // Advance the chain unless stalled; flush kills valid/reg_write everywhere and overrides stall
   always_comb begin
      for (int i = 0; i < MEM_LATENCY; i++) stage_d[i] = stage_q[i];
      wb_d = wb_q;
      if (!stall_i || flush_i) begin
         stage_d[0] = in_e;
         for (int i = 1; i < MEM_LATENCY; i++) stage_d[i] = stage_q[i-1];
         wb_d.valid         = last.valid;
         wb_d.reg_write     = last.reg_write;
         wb_d.misaligned    = last.misaligned;
         wb_d.result_source = last.result_source;
         wb_d.alu_result    = last.alu_result;
         wb_d.instr         = last.instr;
         wb_d.pc_next       = last.pc_next;
         wb_d.read_data     = ld_data;
      end
      if (flush_i) begin
         for (int i = 0; i < MEM_LATENCY; i++) begin
            stage_d[i].valid     = 1'b0;
            stage_d[i].reg_write = 1'b0;
         end
         wb_d.valid     = 1'b0;
         wb_d.reg_write = 1'b0;
      end
   end

   // Stage and writeback registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < MEM_LATENCY; i++) stage_q[i] <= '0;
         wb_q <= '0;
      end else begin
         for (int i = 0; i < MEM_LATENCY; i++) stage_q[i] <= stage_d[i];
         wb_q <= wb_d;
      end
   end

   assign valid_o         = wb_q.valid;
   assign reg_write_o     = wb_q.reg_write;
   assign misaligned_o    = wb_q.misaligned;
   assign result_source_o = wb_q.result_source;
   assign alu_result_o    = wb_q.alu_result;
   assign read_data_o     = wb_q.read_data;
   assign instr_o         = wb_q.instr;
   assign pc_next_o       = wb_q.pc_next;

endmodule
